ysyx_22041412_mdu_ctrl: RTL
===========================

YSYX_22041412_MDU_CTRL -- requirements
Module: ysyx_22041412_mdu_ctrl

Interface
Parameters: none; data width fixed at 64.
REQ-001 SHALL have port clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  request present.
REQ-004 SHALL have port in_ready  output  1  controller can accept a request.
REQ-005 SHALL have port src1  input  64  dividend / multiplicand.
REQ-006 SHALL have port src2  input  64  divisor / multiplier.
REQ-007 SHALL have port func3  input  3  RV M-op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-008 SHALL have port word  input  1  RV64 W-form (opcode 0111011).
REQ-009 SHALL have port flush  input  1  kill in-flight op, synchronous.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  64  final result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE).
REQ-015 Accept on in_valid&&in_ready&&!flush: latch operands, func3 and word; take operand magnitudes per signedness; IDLE->CALC.
REQ-016 Multiply SHALL be radix-2 shift-add over a 128-bit product register, one multiplier bit per cycle.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes.
REQ-018 Iteration count N = 64 (word=0) or 32 (word=1), tracked by a 6-bit down-counter; CALC->DONE after the Nth iteration.
REQ-019 Accept edge is cycle 0; out_valid SHALL first assert in cycle N+1.
REQ-020 Sign fix in the DONE transition: product negated if operand signs differ (signed ops); quotient negated if signs differ; remainder takes dividend sign.
REQ-021 mul returns product[63:0]; mulh/mulhsu/mulhu return product[127:64].
REQ-022 Word ops SHALL use src1[31:0]/src2[31:0] and return result[31:0] sign-extended from bit 31.
REQ-023 Divide by zero: quotient = all ones, remainder = dividend (width-adjusted); IDLE->DONE directly, out_valid in cycle 1.
REQ-024 Signed overflow (most-negative / -1, per width): quotient = dividend, remainder = 0; same 1-cycle path.
REQ-025 word=1 with func3 001/010/011 is illegal: result = 0 via the 1-cycle path.
REQ-026 DONE SHALL hold out_valid and result stable until out_ready; then DONE->IDLE; no same-cycle re-accept.
REQ-027 flush SHALL force IDLE on the next edge from any state; out_valid low; no result delivered; flush beats in_valid in the same cycle.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, out_valid=0, result=0, counter=0, busy=0, in_ready=1, including mid-operation.
REQ-029 No request SHALL be accepted in a cycle where rst_n is low.

Configuration
REQ-030 Macro YSYX_22041412_MDU_ZERO_SKIP_EN defined: multiplies with either operand (width-adjusted) equal to 0 take the 1-cycle path, result 0.
REQ-031 Macro undefined: such multiplies take the full N-cycle latency; divide special cases (REQ-023, REQ-024) are unaffected.

Verification
REQ-032 mul, src1=3, src2=0xFFFF_FFFF_FFFF_FFFB, word=0 -> result 0xFFFF_FFFF_FFFF_FFF1, out_valid in cycle 65.
REQ-033 div -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; mulhu 0xFFFF_FFFF_FFFF_FFFF squared -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-034 divu src2=0 -> 0xFFFF_FFFF_FFFF_FFFF in cycle 1; remu src1=0x1234, src2=0 -> 0x1234.
REQ-035 div 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; rem -> 0; both in cycle 1.
REQ-036 divw src1=0x0000_0001_8000_0000, src2=1 -> 0xFFFF_FFFF_8000_0000, out_valid in cycle 33; with out_ready held low 5 cycles, result stable throughout.
REQ-037 flush in cycle 10 of a mul -> out_valid never asserts, in_ready=1 in cycle 11; rst_n pulsed low mid-div -> all REQ-028 values immediately.

Source files
------------

// File: rtl/ysyx_22041412_mdu_ctrl.sv
// ysyx_22041412_mdu_ctrl: iterative RV64M multiply/divide controller (shift-add multiply, restoring divide)
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake with src1, src2, func3, word;
// flush kills any in-flight op; out_valid/out_ready result handshake with result; busy = not IDLE.
// Option: YSYX_22041412_MDU_ZERO_SKIP_EN makes multiplies by zero finish on the 1-cycle path.
module ysyx_22041412_mdu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [2:0]  func3,
  input  logic        word,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e       state_q, state_d;
  logic [127:0] prod_q, prod_d, p_nxt, full;
  logic [63:0]  opnd_q, opnd_d, result_q, result_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   fn_q, fn_d;
  logic         word_q, word_d, a_neg_q, a_neg_d, neg_q, neg_d;
  logic         is_div, sa, sb, a_neg, b_neg, div_zero, ovf, illegal, zero_mul, fast;
  logic [63:0]  a_w, b_w, mag_a, mag_b, fast_res, q64, qf, rf, div_r, div_out, mul_out, res_calc;
  logic [64:0]  sum, top, diff;
  logic [127:0] sh;
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
  always_comb begin
    is_div   = func3[2];
    sa       = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    sb       = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    a_w      = word ? (sa ? sx32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
    b_w      = word ? (sb ? sx32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
    a_neg    = sa && a_w[63];
    b_neg    = sb && b_w[63];
    mag_a    = a_neg ? -a_w : a_w;
    mag_b    = b_neg ? -b_w : b_w;
    div_zero = is_div && (b_w == 64'd0);
    ovf      = is_div && !func3[0] && (b_w == '1) &&
               (a_w == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    illegal  = word && !func3[2] && (func3[1:0] != 2'b00);
`ifdef YSYX_22041412_MDU_ZERO_SKIP_EN
    zero_mul = !is_div && ((a_w == 64'd0) || (b_w == 64'd0));
`else
    zero_mul = 1'b0;
`endif
    fast     = div_zero || ovf || illegal || zero_mul;
    // Both special divide cases return either the (width-adjusted) dividend, zero or all ones.
    fast_res = (illegal || zero_mul) ? 64'd0 :
               div_zero ? (func3[1] ? (word ? sx32(a_w[31:0]) : a_w) : '1) :
               (func3[1] ? 64'd0 : a_w);
  end
  always_comb begin
    // Multiply: conditionally add multiplicand to the upper half, then shift the pair right.
    sum  = {1'b0, prod_q[127:64]} + (prod_q[0] ? {1'b0, opnd_q} : 65'd0);
    // Divide: shift {rem, dividend/quotient} left; the bit shifted out is the remainder's 65th bit.
    sh   = {prod_q[126:0], 1'b0};
    top  = {prod_q[127], sh[127:64]};
    diff = top - {1'b0, opnd_q};
    p_nxt = fn_q[2] ? (diff[64] ? sh : {diff[63:0], sh[63:1], 1'b1}) : {sum, prod_q[63:1]};
    full    = neg_q ? -p_nxt : p_nxt;
    q64     = word_q ? {32'b0, p_nxt[31:0]} : p_nxt[63:0];
    qf      = neg_q ? -q64 : q64;
    rf      = a_neg_q ? -p_nxt[127:64] : p_nxt[127:64];
    div_r   = fn_q[1] ? rf : qf;
    div_out = word_q ? sx32(div_r[31:0]) : div_r;
    // A 32-iteration word multiply leaves its product shifted up by 32.
    mul_out = word_q ? sx32(p_nxt[63:32]) : ((fn_q[1:0] == 2'b00) ? full[63:0] : full[127:64]);
    res_calc = fn_q[2] ? div_out : mul_out;
  end
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    word_d   = word_q;
    a_neg_d  = a_neg_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d  = fast ? DONE : CALC;
        result_d = fast_res;
        prod_d   = is_div ? {64'd0, word ? {mag_a[31:0], 32'd0} : mag_a} : {64'd0, mag_b};
        opnd_d   = is_div ? mag_b : mag_a;
        cnt_d    = fast ? 6'd0 : (word ? 6'd31 : 6'd63);
        fn_d     = func3;
        word_d   = word;
        a_neg_d  = a_neg;
        neg_d    = a_neg ^ b_neg;
      end
      CALC: begin
        prod_d = p_nxt;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd0) begin
          state_d  = DONE;
          result_d = res_calc;
          cnt_d    = 6'd0;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      fn_q     <= '0;
      word_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      word_q   <= word_d;
      a_neg_q  <= a_neg_d;
      neg_q    <= neg_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = (state_q == DONE) && !flush;
  assign result    = result_q;
endmodule
